// File: rtl/opmem_scheduler_pkg.sv
// Shared definitions for the op-memory scheduler, its memory and its client blocks.
// Holds the phase encoding and the default memory geometry.
package opmem_scheduler_pkg;

  localparam int OPMEM_ADDR_W = 7;
  localparam int OPMEM_DATA_W = 11;

  typedef enum logic [1:0] {
    EDIT  = 2'd0,
    DRAIN = 2'd1,
    SHOW  = 2'd2
  } phase_e;

endpackage

// File: rtl/opmem_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational; ptr=0 favours req[0], ptr=1 favours req[1].
// An uncontested request always wins regardless of ptr.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!ptr || !req[1])) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/opmem_scheduler.sv
// Op-memory write scheduler: gnt/wren/address/data registered together one cycle after arbitration.
// Requests not granted (wrong phase, budget spent, contention) simply stay pending; define OPMEM_SCHED_STATS_EN for denied_count.
module opmem_scheduler
  import opmem_scheduler_pkg::*;
#(
  parameter int WRITE_BUDGET = 64,
  parameter int ADDR_W       = OPMEM_ADDR_W,
  parameter int DATA_W       = OPMEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              req_ed,
  input  logic [ADDR_W-1:0] addr_ed,
  input  logic [DATA_W-1:0] data_ed,
  input  logic              req_kb,
  input  logic [ADDR_W-1:0] addr_kb,
  input  logic [DATA_W-1:0] data_kb,
  output logic              gnt_ed,
  output logic              gnt_kb,
  output logic [ADDR_W-1:0] address_write,
  output logic [DATA_W-1:0] data_write,
  output logic              wren,
  output logic              next_screen,
  output logic              new_state,
  output logic [1:0]        phase,
  output logic [7:0]        denied_count
);

  phase_e     state_q, state_d;
  logic [7:0] budget_q;
  logic       ptr_q;
  logic       grant_ok;
  logic       enter_edit;
  logic [1:0] elig;
  logic [1:0] win;
  logic [1:0] win_g;

  // A requester already showing a grant this cycle is still holding its old request.
  assign elig = {req_kb & ~gnt_kb, req_ed & ~gnt_ed};

  rr_arbiter2 u_arb (
    .req (elig),
    .ptr (ptr_q),
    .gnt (win)
  );

  always_comb begin
    state_d    = state_q;
    grant_ok   = 1'b0;
    enter_edit = 1'b0;
    case (state_q)
      EDIT: begin
        if (frame_end) begin
          state_d = DRAIN;
        end else begin
          grant_ok = (budget_q != 8'd0);
        end
      end
      DRAIN: state_d = SHOW;
      SHOW: begin
        if (frame_start && !frame_end) begin
          state_d    = EDIT;
          enter_edit = 1'b1;
        end
      end
      default: state_d = EDIT;
    endcase
  end

  assign win_g = grant_ok ? win : 2'b00;
  assign phase = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= EDIT;
      budget_q      <= 8'(WRITE_BUDGET);
      ptr_q         <= 1'b0;
      gnt_ed        <= 1'b0;
      gnt_kb        <= 1'b0;
      wren          <= 1'b0;
      address_write <= '0;
      data_write    <= '0;
      next_screen   <= 1'b0;
      new_state     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_ed      <= win_g[0];
      gnt_kb      <= win_g[1];
      wren        <= |win_g;
      next_screen <= (state_q == DRAIN);
      new_state   <= enter_edit;
      if (win_g[0]) begin
        address_write <= addr_ed;
        data_write    <= data_ed;
        ptr_q         <= 1'b1;
      end else if (win_g[1]) begin
        address_write <= addr_kb;
        data_write    <= data_kb;
        ptr_q         <= 1'b0;
      end
      if (enter_edit) begin
        budget_q <= 8'(WRITE_BUDGET);
      end else if (|win_g) begin
        budget_q <= budget_q - 8'd1;
      end
    end
  end

`ifdef OPMEM_SCHED_STATS_EN
  logic [7:0] denied_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      denied_q <= 8'd0;
    end else if ((state_q == EDIT) && (req_ed || req_kb) && (budget_q == 8'd0) &&
                 (win_g == 2'b00) && (denied_q != 8'hFF)) begin
      denied_q <= denied_q + 8'd1;
    end
  end

  assign denied_count = denied_q;
`else
  assign denied_count = 8'd0;
`endif

endmodule

// File: tb/tb_opmem_scheduler.sv
// Directed bench for opmem_scheduler (WRITE_BUDGET=3); expected writes go into a queue checked by a monitor.
module tb_opmem_scheduler;

  typedef struct packed {
    logic        kb;
    logic [6:0]  addr;
    logic [10:0] data;
  } exp_t;

`ifdef OPMEM_SCHED_STATS_EN
  localparam int DEN3 = 3;
`else
  localparam int DEN3 = 0;
`endif

  logic        clk, reset, frame_start, frame_end;
  logic        req_ed, req_kb;
  logic [6:0]  addr_ed, addr_kb;
  logic [10:0] data_ed, data_kb;
  logic        gnt_ed, gnt_kb, wren, next_screen, new_state;
  logic [6:0]  address_write;
  logic [10:0] data_write;
  logic [1:0]  phase;
  logic [7:0]  denied_count;

  int   n_cmp = 0;
  int   n_err = 0;
  int   wren_cnt = 0;
  int   base;
  exp_t exp_q[$];
  exp_t e;

  opmem_scheduler #(.WRITE_BUDGET(3)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
    .req_ed(req_ed), .addr_ed(addr_ed), .data_ed(data_ed),
    .req_kb(req_kb), .addr_kb(addr_kb), .data_kb(data_kb),
    .gnt_ed(gnt_ed), .gnt_kb(gnt_kb),
    .address_write(address_write), .data_write(data_write), .wren(wren),
    .next_screen(next_screen), .new_state(new_state),
    .phase(phase), .denied_count(denied_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic push(input logic kb, input logic [6:0] a, input logic [10:0] d);
    exp_q.push_back('{kb: kb, addr: a, data: d});
  endtask

  task automatic do_reset();
    req_ed = 0; req_kb = 0; frame_start = 0; frame_end = 0;
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  // Monitor: every write must match the next expected grant and never land in SHOW.
  always @(negedge clk) begin
    if (wren) begin
      wren_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr %0h data %0h, no write expected", address_write, data_write);
      end else begin
        e = exp_q.pop_front();
        if ({gnt_kb, gnt_ed, address_write, data_write} !== {e.kb, ~e.kb, e.addr, e.data}) begin
          n_err++;
          $display("FAIL write: got kb=%0b ed=%0b addr=%0h data=%0h expected kb=%0b addr=%0h data=%0h",
                   gnt_kb, gnt_ed, address_write, data_write, e.kb, e.addr, e.data);
        end
      end
      n_cmp++;
      if (phase == 2'd2) begin
        n_err++;
        $display("FAIL write_in_show: got phase %0d expected not 2", phase);
      end
    end else if (gnt_ed || gnt_kb) begin
      n_cmp++;
      n_err++;
      $display("FAIL grant_without_wren: got gnt_ed=%0b gnt_kb=%0b expected wren=1", gnt_ed, gnt_kb);
    end
  end

  initial begin
    reset = 1; frame_start = 0; frame_end = 0;
    req_ed = 0; req_kb = 0; addr_ed = 0; addr_kb = 0; data_ed = 0; data_kb = 0;

    // Reset state
    tick();
    tick();
    chk("rst_phase", phase, 0);
    chk("rst_wren", wren, 0);
    chk("rst_gnt", {gnt_ed, gnt_kb}, 0);
    chk("rst_pulses", {next_screen, new_state}, 0);
    chk("rst_addr_data", {address_write, data_write}, 0);
    chk("rst_denied", denied_count, 0);
    reset = 0;

    // Single write: grant, single wren, then hold of address/data
    req_ed = 1; addr_ed = 7'h05; data_ed = 11'h123; push(0, 7'h05, 11'h123);
    tick();
    chk("single_gnt_ed", gnt_ed, 1);
    chk("single_wren", wren, 1);
    tick();
    req_ed = 0;
    chk("single_no_second_pulse", wren, 0);
    tick();
    chk("single_hold_addr", address_write, 7'h05);
    chk("single_hold_data", data_write, 11'h123);

    // Alternation across two edit windows, with frame sequencing
    do_reset();
    req_ed = 1; addr_ed = 7'h11; data_ed = 11'h0AA;
    req_kb = 1; addr_kb = 7'h22; data_kb = 11'h155;
    push(0, 7'h11, 11'h0AA); push(1, 7'h22, 11'h155); push(0, 7'h11, 11'h0AA);
    tick(); tick(); tick();               // c3: third grant visible, budget now 0
    chk("alt_third_is_ed", gnt_ed, 1);
    tick();                               // c4
    chk("alt_budget_stall", wren, 0);
    tick();                               // c5
    frame_end = 1;
    tick();                               // c6
    frame_end = 0;
    chk("alt_phase_drain", phase, 1);
    tick();                               // c7
    chk("alt_phase_show", phase, 2);
    chk("alt_next_screen", next_screen, 1);
    tick();                               // c8
    chk("alt_next_screen_once", next_screen, 0);
    push(1, 7'h22, 11'h155); push(0, 7'h11, 11'h0AA); push(1, 7'h22, 11'h155);
    frame_start = 1;
    tick();                               // c9
    frame_start = 0;
    chk("alt_phase_edit", phase, 0);
    chk("alt_new_state", new_state, 1);
    tick();                               // c10
    chk("alt_new_state_once", new_state, 0);
    chk("alt_window2_kb_first", gnt_kb, 1);
    tick(); tick();                       // c12
    req_ed = 0; req_kb = 0;
    chk("alt_denied", denied_count, DEN3);
    tick();

    // Budget of 3 with 5 requests
    do_reset();
    base = wren_cnt;
    req_ed = 1; addr_ed = 7'h40; data_ed = 11'h100; push(0, 7'h40, 11'h100);
    tick();
    addr_ed = 7'h41; data_ed = 11'h101; push(0, 7'h41, 11'h101);
    tick(); tick();
    addr_ed = 7'h42; data_ed = 11'h102; push(0, 7'h42, 11'h102);
    tick(); tick();
    addr_ed = 7'h43; data_ed = 11'h103;
    tick();
    addr_ed = 7'h44; data_ed = 11'h104;
    tick(); tick();                       // c8
    chk("budget_wren_count", wren_cnt - base, 3);
    chk("budget_denied", denied_count, DEN3);
    req_ed = 0;
    tick();

    // Request during SHOW waits for frame_start
    do_reset();
    frame_end = 1;
    tick();
    frame_end = 0;
    chk("show_phase1", phase, 1);
    tick();
    chk("show_phase2", phase, 2);
    req_kb = 1; addr_kb = 7'h33; data_kb = 11'h7FF;
    tick();
    chk("show_no_grant_a", gnt_kb, 0);
    frame_end = 1;
    tick();
    frame_end = 0;
    chk("show_fe_ignored", phase, 2);
    chk("show_no_grant_b", gnt_kb, 0);
    frame_start = 1;
    tick();
    frame_start = 0;
    chk("show_to_edit", phase, 0);
    chk("show_new_state", new_state, 1);
    push(1, 7'h33, 11'h7FF);
    tick();
    chk("show_grant_after", gnt_kb, 1);
    req_kb = 0;
    tick();

    // Simultaneous frame_start/frame_end
    do_reset();
    frame_start = 1; frame_end = 1;
    tick();
    frame_end = 0;
    chk("sim_to_drain", phase, 1);
    tick();
    chk("sim_fs_in_drain_ignored", {phase, new_state}, {2'd2, 1'b0});
    frame_end = 1;
    tick();
    frame_start = 0; frame_end = 0;
    chk("sim_in_show_stays", {phase, new_state}, {2'd2, 1'b0});

    // Reset in SHOW with a pending request
    do_reset();
    frame_end = 1;
    tick();
    frame_end = 0;
    tick();
    req_ed = 1; addr_ed = 7'h7F; data_ed = 11'h7FF;
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_phase", phase, 0);
    chk("mid_rst_outputs", {gnt_ed, gnt_kb, wren, next_screen, new_state}, 0);
    chk("mid_rst_denied", denied_count, 0);
    push(0, 7'h7F, 11'h7FF);
    tick();
    chk("mid_rst_grant", gnt_ed, 1);
    req_ed = 0;
    tick();
    tick();

    chk("leftover_expected", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
